// File: rtl/mem_pkg.sv
// Shared line format and constants for the cache back side and backing memory.
package mem_pkg;

  localparam int LINE_BYTES = 16;
  localparam int ADDR_W     = 32;

  typedef struct packed {
    logic [8*LINE_BYTES-1:0] dat;
    logic [LINE_BYTES-1:0]   bo;
  } mem_line;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BUSY,
    ST_DONE,
    ST_WAIT_DROP
  } mem_state_e;

  function automatic mem_line merge_line(input mem_line old,
                                         input logic [8*LINE_BYTES-1:0] dat,
                                         input logic [LINE_BYTES-1:0] mask);
    mem_line res;
    res = old;
    for (int j = 0; j < LINE_BYTES; j++) begin
      if (mask[j]) res.dat[8*j +: 8] = dat[8*j +: 8];
    end
    res.bo = old.bo | mask;
    return res;
  endfunction

endpackage

// File: rtl/mem_lat_ctr.sv
// Latency down-counter: load a start value, count to zero, flag terminal count.
module mem_lat_ctr #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst)                      cnt <= '0;
    else if (load)                cnt <= load_val;
    else if (dec && cnt != '0)    cnt <= cnt - W'(1);
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/backing_mem.sv
// Line-granular backing store with fixed request latency for the cache back side.
// Optional request statistics outputs are enabled by defining BACKING_MEM_STATS_EN.
//
//   state        | meaning
//   ST_IDLE      | waiting for a single bs_we or bs_re request
//   ST_BUSY      | latency countdown; dropped request aborts
//   ST_DONE      | one-cycle bs_done (and bs_err) pulse
//   ST_WAIT_DROP | waiting for requester to release bs_we/bs_re
module backing_mem
  import mem_pkg::*;
#(
  parameter int DEPTH   = 1024,
  parameter int LATENCY = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [ADDR_W-1:0]       bs_addr,
  input  logic [8*LINE_BYTES-1:0] bs_dinp,
  input  logic [LINE_BYTES-1:0]   bs_boinp,
  input  logic                    bs_we,
  input  logic                    bs_re,
  output logic [8*LINE_BYTES-1:0] bs_doup,
  output logic [LINE_BYTES-1:0]   bs_booup,
  output logic                    bs_done,
  output logic                    bs_err
`ifdef BACKING_MEM_STATS_EN
  ,
  output logic [31:0]             stat_wr,
  output logic [31:0]             stat_rd,
  output logic [31:0]             stat_err
`endif
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int HI_LSB = 4 + IDX_W;
  localparam logic [7:0] LOAD_VAL = 8'(LATENCY - 1);

  mem_state_e state;
  mem_line    mem [DEPTH];

  logic [IDX_W-1:0]        lat_idx;
  logic [8*LINE_BYTES-1:0] lat_dat;
  logic [LINE_BYTES-1:0]   lat_bo;
  logic                    lat_wr;
  logic                    lat_err;

  logic req_any, addr_bad, cnt_zero, addr_unused;

  assign req_any     = bs_we | bs_re;
  assign addr_unused = ^bs_addr[3:0];

  generate
    if (HI_LSB < ADDR_W) begin : g_hi
      assign addr_bad = |bs_addr[ADDR_W-1:HI_LSB];
    end else begin : g_no_hi
      assign addr_bad = 1'b0;
    end
  endgenerate

  mem_lat_ctr #(.W(8)) u_lat_ctr (
    .clk      (clk),
    .rst      (rst),
    .load     (state == ST_IDLE && req_any),
    .load_val (LOAD_VAL),
    .dec      (state == ST_BUSY),
    .zero     (cnt_zero)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      bs_done  <= 1'b0;
      bs_err   <= 1'b0;
      bs_doup  <= '0;
      bs_booup <= '0;
      lat_idx  <= '0;
      lat_dat  <= '0;
      lat_bo   <= '0;
      lat_wr   <= 1'b0;
      lat_err  <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      bs_done <= 1'b0;
      bs_err  <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (req_any) begin
            lat_idx <= bs_addr[4 +: IDX_W];
            lat_dat <= bs_dinp;
            lat_bo  <= bs_boinp;
            lat_wr  <= bs_we;
            lat_err <= (bs_we & bs_re) | addr_bad;
            state   <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          if (!req_any) begin
            state <= ST_IDLE;
          end else if (cnt_zero) begin
            state   <= ST_DONE;
            bs_done <= 1'b1;
            bs_err  <= lat_err;
            if (lat_err) begin
              bs_doup  <= '0;
              bs_booup <= '0;
            end else if (lat_wr) begin
              mem[lat_idx] <= merge_line(mem[lat_idx], lat_dat, lat_bo);
            end else begin
              bs_doup  <= mem[lat_idx].dat;
              bs_booup <= mem[lat_idx].bo;
            end
          end
        end
        ST_DONE:      state <= ST_WAIT_DROP;
        ST_WAIT_DROP: if (!req_any) state <= ST_IDLE;
        default:      state <= ST_IDLE;
      endcase
    end
  end

`ifdef BACKING_MEM_STATS_EN
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == '1) ? v : v + 32'd1;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      stat_wr  <= '0;
      stat_rd  <= '0;
      stat_err <= '0;
    end else if (state == ST_DONE) begin
      if (lat_err)     stat_err <= sat_inc(stat_err);
      else if (lat_wr) stat_wr  <= sat_inc(stat_wr);
      else             stat_rd  <= sat_inc(stat_rd);
    end
  end
`endif

endmodule
